// File: rtl/probe_pkg.sv
// Shared encodings for the probe receiver: packet flag values, FSM states,
// status bit positions and a small saturating-increment helper.
package probe_pkg;

    localparam logic [1:0] FLAG_NONE    = 2'd0;
    localparam logic [1:0] FLAG_SMALL   = 2'd1;
    localparam logic [1:0] FLAG_ILLEGAL = 2'd2;
    localparam logic [1:0] FLAG_REG     = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        RX         = 2'd2
    } probeStateT;

    localparam int ST_TIMEOUT = 0;
    localparam int ST_IPD     = 1;
    localparam int ST_MIXED   = 2;
    localparam int ST_ILLEGAL = 3;

    // 8-bit increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/probe_ipd_counter.sv
// Idle/IPD cycle counter for the probe receiver. Counts cycles since the
// last accepted packet (or since start), saturating at all-ones, and
// provides the timeout compare plus the expected-IPD tolerance check.
module probe_ipd_counter #(
    parameter int unsigned IPD_TOL = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] expInterval,
    output logic [31:0] count,
    output logic [31:0] ipd,
    output logic        timedOut,
    output logic        ipdOutside
);

    localparam logic [32:0] TOL33 = 33'(IPD_TOL);
    localparam logic [32:0] MAX32 = {1'b0, 32'hFFFF_FFFF};

    logic [32:0] center;
    logic [32:0] lowBound;
    logic [32:0] highRaw;
    logic [32:0] highBound;

    // Count cycles while armed; a clear lands the count at zero for the next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (enable && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    // The event cycle itself closes the interval, so the IPD is one more than the count
    assign ipd      = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    assign timedOut = (count > TIMEOUT);

    // Tolerance window around I+1, evaluated in 33 bits and clamped to the 32-bit range
    always_comb begin
        center     = {1'b0, expInterval} + 33'd1;
        lowBound   = (center > TOL33) ? (center - TOL33) : 33'd0;
        highRaw    = center + TOL33;
        highBound  = (highRaw > MAX32) ? MAX32 : highRaw;
        ipdOutside = ({1'b0, ipd} < lowBound) || ({1'b0, ipd} > highBound);
    end

endmodule

// File: rtl/probe_receiver.sv
// Receive-side monitor for the probe packet stream. Detects packets as
// flag rising events, tracks one armed session, gathers per-type counts
// and IPD statistics, and raises done with sticky status bits when the
// probe completes or times out.
module probe_receiver
    import probe_pkg::*;
#(
    parameter int unsigned PKT_NUMBER = 4,
    parameter int unsigned IPD_TOL    = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] exp_interval,
    input  logic [1:0]  session_id,
    input  logic [1:0]  pkt_flag,
    output logic        busy,
    output logic        done,
    output logic [3:0]  status,
    output logic [7:0]  small_cnt,
    output logic [7:0]  reg_cnt,
    output logic [31:0] ipd_min,
    output logic [31:0] ipd_max,
    output logic [31:0] last_ipd,
    output logic [7:0]  stray_cnt
);

    probeStateT  state;
    logic [1:0]  prevFlag;
    logic [1:0]  session;
    logic [31:0] expInterval;
    logic [1:0]  refType;
    logic [31:0] pktTotal;

    logic        flagEvent;
    logic        armed;
    logic        matchEvent;
    logic        legalMatch;
    logic        counterClear;
    logic [31:0] ipdCount;
    logic [31:0] ipdValue;
    logic        timedOut;
    logic        ipdOutside;

    assign armed        = (state != IDLE);
    assign busy         = armed;
    assign flagEvent    = (pkt_flag != FLAG_NONE) && (prevFlag == FLAG_NONE);
    assign matchEvent   = flagEvent && armed && (session_id == session);
    assign legalMatch   = matchEvent && (pkt_flag != FLAG_ILLEGAL);
    assign counterClear = start || legalMatch;

    probe_ipd_counter #(
        .IPD_TOL (IPD_TOL),
        .TIMEOUT (TIMEOUT)
    ) ipdCounter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (counterClear),
        .enable      (armed),
        .expInterval (expInterval),
        .count       (ipdCount),
        .ipd         (ipdValue),
        .timedOut    (timedOut),
        .ipdOutside  (ipdOutside)
    );

    // Probe FSM: arming, packet accounting, IPD statistics and the done/status verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prevFlag    <= FLAG_NONE;
            session     <= 2'd0;
            expInterval <= 32'd0;
            refType     <= FLAG_NONE;
            pktTotal    <= 32'd0;
            done        <= 1'b0;
            status      <= 4'd0;
            small_cnt   <= 8'd0;
            reg_cnt     <= 8'd0;
            ipd_min     <= 32'hFFFF_FFFF;
            ipd_max     <= 32'd0;
            last_ipd    <= 32'd0;
            stray_cnt   <= 8'd0;
        end else begin
            done     <= 1'b0;
            prevFlag <= pkt_flag;
            if (start) begin
                state       <= WAIT_FIRST;
                session     <= session_id;
                expInterval <= exp_interval;
                refType     <= FLAG_NONE;
                pktTotal    <= 32'd0;
                status      <= 4'd0;
                small_cnt   <= 8'd0;
                reg_cnt     <= 8'd0;
                ipd_min     <= 32'hFFFF_FFFF;
                ipd_max     <= 32'd0;
                last_ipd    <= 32'd0;
            end else begin
                if (flagEvent && !matchEvent) begin
                    stray_cnt <= satInc8(stray_cnt);
                end
                if (matchEvent && (pkt_flag == FLAG_ILLEGAL)) begin
                    status[ST_ILLEGAL] <= 1'b1;
                end
                if (armed) begin
                    if (legalMatch) begin
                        if (pkt_flag == FLAG_SMALL) begin
                            small_cnt <= satInc8(small_cnt);
                        end else begin
                            reg_cnt <= satInc8(reg_cnt);
                        end
                        pktTotal <= pktTotal + 32'd1;
                        if (state == WAIT_FIRST) begin
                            refType <= pkt_flag;
                        end else begin
                            last_ipd <= ipdValue;
                            if (ipdValue < ipd_min) begin
                                ipd_min <= ipdValue;
                            end
                            if (ipdValue > ipd_max) begin
                                ipd_max <= ipdValue;
                            end
                            if (ipdOutside) begin
                                status[ST_IPD] <= 1'b1;
                            end
                            if (pkt_flag != refType) begin
                                status[ST_MIXED] <= 1'b1;
                            end
                        end
                        if ((pktTotal + 32'd1) >= 32'(PKT_NUMBER)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= RX;
                        end
                    end else if (timedOut) begin
                        status[ST_TIMEOUT] <= 1'b1;
                        state              <= IDLE;
                        done               <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_probe_receiver.sv
// Directed testbench for probe_receiver: nominal, held-flag/stray, IPD
// violation, mixed and illegal flags, timeouts, restart and async reset.
module tb_probe_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] exp_interval;
    logic [1:0]  session_id;
    logic [1:0]  pkt_flag;
    logic        busy;
    logic        done;
    logic [3:0]  status;
    logic [7:0]  small_cnt;
    logic [7:0]  reg_cnt;
    logic [31:0] ipd_min;
    logic [31:0] ipd_max;
    logic [31:0] last_ipd;
    logic [7:0]  stray_cnt;

    int checkCount = 0;
    int failCount  = 0;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    probe_receiver #(
        .PKT_NUMBER (4),
        .IPD_TOL    (2),
        .TIMEOUT    (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .exp_interval (exp_interval),
        .session_id   (session_id),
        .pkt_flag     (pkt_flag),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .small_cnt    (small_cnt),
        .reg_cnt      (reg_cnt),
        .ipd_min      (ipd_min),
        .ipd_max      (ipd_max),
        .last_ipd     (last_ipd),
        .stray_cnt    (stray_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] flag, input logic [1:0] sid, input int hold, input int gap);
        pkt_flag   = flag;
        session_id = sid;
        tick(hold);
        pkt_flag = 2'd0;
        tick(gap);
    endtask

    task automatic startProbe(input logic [31:0] interval, input logic [1:0] sid);
        start        = 1'b1;
        exp_interval = interval;
        session_id   = sid;
        tick(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while ((done !== 1'b1) && (n < budget)) begin
            tick(1);
            n++;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    // Main directed sequence
    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        exp_interval = 32'd0;
        session_id   = 2'd0;
        pkt_flag     = 2'd0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] reset values");
        checkOutput("rst busy", {31'd0, busy}, 32'd0);
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst status", {28'd0, status}, 32'd0);
        checkOutput("rst small", {24'd0, small_cnt}, 32'd0);
        checkOutput("rst reg", {24'd0, reg_cnt}, 32'd0);
        checkOutput("rst ipd_min", ipd_min, 32'hFFFF_FFFF);
        checkOutput("rst ipd_max", ipd_max, 32'd0);
        checkOutput("rst last_ipd", last_ipd, 32'd0);
        checkOutput("rst stray", {24'd0, stray_cnt}, 32'd0);

        $display("[TB] nominal regular probe");
        startProbe(32'd20, 2'd1);
        checkOutput("nom busy", {31'd0, busy}, 32'd1);
        applyStimulus(2'd3, 2'd1, 1, 20);
        applyStimulus(2'd3, 2'd1, 1, 20);
        applyStimulus(2'd3, 2'd1, 1, 20);
        checkOutput("nom early done", {31'd0, done}, 32'd0);
        applyStimulus(2'd3, 2'd1, 1, 0);
        checkOutput("nom done", {31'd0, done}, 32'd1);
        checkOutput("nom busy off", {31'd0, busy}, 32'd0);
        checkOutput("nom status", {28'd0, status}, 32'd0);
        checkOutput("nom reg", {24'd0, reg_cnt}, 32'd4);
        checkOutput("nom small", {24'd0, small_cnt}, 32'd0);
        checkOutput("nom ipd_min", ipd_min, 32'd21);
        checkOutput("nom ipd_max", ipd_max, 32'd21);
        checkOutput("nom last_ipd", last_ipd, 32'd21);
        tick(1);
        checkOutput("nom done pulse", {31'd0, done}, 32'd0);

        $display("[TB] held flag and stray traffic");
        startProbe(32'd20, 2'd1);
        applyStimulus(2'd3, 2'd1, 1, 4);
        applyStimulus(2'd3, 2'd2, 1, 15);
        applyStimulus(2'd3, 2'd1, 1, 4);
        applyStimulus(2'd3, 2'd2, 1, 15);
        applyStimulus(2'd3, 2'd1, 1, 20);
        pkt_flag   = 2'd3;
        session_id = 2'd1;
        tick(1);
        checkOutput("held done", {31'd0, done}, 32'd1);
        tick(5);
        pkt_flag = 2'd0;
        tick(1);
        checkOutput("held stray", {24'd0, stray_cnt}, 32'd2);
        checkOutput("held reg", {24'd0, reg_cnt}, 32'd4);
        checkOutput("held status", {28'd0, status}, 32'd0);
        checkOutput("held ipd_max", ipd_max, 32'd21);
        applyStimulus(2'd3, 2'd0, 1, 1);
        checkOutput("idle stray", {24'd0, stray_cnt}, 32'd3);

        $display("[TB] IPD violation");
        startProbe(32'd20, 2'd1);
        applyStimulus(2'd3, 2'd1, 1, 20);
        applyStimulus(2'd3, 2'd1, 1, 24);
        applyStimulus(2'd3, 2'd1, 1, 20);
        checkOutput("ipd early done", {31'd0, done}, 32'd0);
        applyStimulus(2'd3, 2'd1, 1, 0);
        checkOutput("ipd done", {31'd0, done}, 32'd1);
        checkOutput("ipd status", {28'd0, status}, 32'h2);
        checkOutput("ipd max", ipd_max, 32'd25);
        checkOutput("ipd min", ipd_min, 32'd21);
        checkOutput("ipd last", last_ipd, 32'd21);

        $display("[TB] mixed types");
        startProbe(32'd10, 2'd1);
        applyStimulus(2'd1, 2'd1, 1, 10);
        applyStimulus(2'd3, 2'd1, 1, 10);
        applyStimulus(2'd1, 2'd1, 1, 10);
        applyStimulus(2'd1, 2'd1, 1, 0);
        checkOutput("mix done", {31'd0, done}, 32'd1);
        checkOutput("mix status", {28'd0, status}, 32'h4);
        checkOutput("mix small", {24'd0, small_cnt}, 32'd3);
        checkOutput("mix reg", {24'd0, reg_cnt}, 32'd1);

        $display("[TB] illegal flag");
        startProbe(32'd10, 2'd1);
        applyStimulus(2'd1, 2'd1, 1, 4);
        applyStimulus(2'd2, 2'd1, 1, 5);
        applyStimulus(2'd1, 2'd1, 1, 10);
        applyStimulus(2'd1, 2'd1, 1, 10);
        applyStimulus(2'd1, 2'd1, 1, 0);
        checkOutput("ill done", {31'd0, done}, 32'd1);
        checkOutput("ill status", {28'd0, status}, 32'h8);
        checkOutput("ill small", {24'd0, small_cnt}, 32'd4);
        checkOutput("ill reg", {24'd0, reg_cnt}, 32'd0);
        checkOutput("ill ipd_max", ipd_max, 32'd11);

        $display("[TB] timeout with no packets");
        startProbe(32'd20, 2'd1);
        tick(250);
        checkOutput("to0 early done", {31'd0, done}, 32'd0);
        checkOutput("to0 still busy", {31'd0, busy}, 32'd1);
        waitDone("to0 done", 20);
        checkOutput("to0 status", {28'd0, status}, 32'h1);
        checkOutput("to0 small", {24'd0, small_cnt}, 32'd0);
        checkOutput("to0 reg", {24'd0, reg_cnt}, 32'd0);
        checkOutput("to0 ipd_min", ipd_min, 32'hFFFF_FFFF);

        $display("[TB] timeout after two packets");
        startProbe(32'd20, 2'd1);
        applyStimulus(2'd1, 2'd1, 1, 20);
        applyStimulus(2'd1, 2'd1, 1, 0);
        waitDone("to2 done", 300);
        checkOutput("to2 status", {28'd0, status}, 32'h1);
        checkOutput("to2 small", {24'd0, small_cnt}, 32'd2);
        checkOutput("to2 last_ipd", last_ipd, 32'd21);

        $display("[TB] restart mid-probe");
        startProbe(32'd20, 2'd1);
        applyStimulus(2'd1, 2'd1, 1, 20);
        applyStimulus(2'd1, 2'd1, 1, 5);
        startProbe(32'd30, 2'd2);
        checkOutput("rs no done", {31'd0, done}, 32'd0);
        checkOutput("rs busy", {31'd0, busy}, 32'd1);
        checkOutput("rs small", {24'd0, small_cnt}, 32'd0);
        checkOutput("rs ipd_min", ipd_min, 32'hFFFF_FFFF);
        checkOutput("rs last_ipd", last_ipd, 32'd0);
        applyStimulus(2'd3, 2'd2, 1, 30);
        applyStimulus(2'd3, 2'd2, 1, 30);
        applyStimulus(2'd3, 2'd2, 1, 30);
        applyStimulus(2'd3, 2'd2, 1, 0);
        checkOutput("rs done", {31'd0, done}, 32'd1);
        checkOutput("rs status", {28'd0, status}, 32'd0);
        checkOutput("rs reg", {24'd0, reg_cnt}, 32'd4);
        checkOutput("rs ipd_max", ipd_max, 32'd31);
        checkOutput("rs stray", {24'd0, stray_cnt}, 32'd3);

        $display("[TB] async reset mid-probe");
        startProbe(32'd20, 2'd1);
        applyStimulus(2'd1, 2'd1, 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar busy", {31'd0, busy}, 32'd0);
        checkOutput("ar ipd_min", ipd_min, 32'hFFFF_FFFF);
        checkOutput("ar small", {24'd0, small_cnt}, 32'd0);
        checkOutput("ar stray", {24'd0, stray_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        checkOutput("ar done", {31'd0, done}, 32'd0);
        checkOutput("ar busy after", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
